// File: rtl/lfsr_step_if.sv
// Handshake/bus bundle for lfsr_step: step enable, data and state in, registered results out.
// Ports: en, data_in, state_in (master -> slave); state_out, data_out, out_valid (slave -> master).
// The master modport belongs to the caller and the slave modport to the LFSR engine.
interface lfsr_step_if #(
  parameter int LFSR_WIDTH = 31,
  parameter int DATA_WIDTH = 8
);
  logic                  en;
  logic [DATA_WIDTH-1:0] data_in;
  logic [LFSR_WIDTH-1:0] state_in;
  logic [LFSR_WIDTH-1:0] state_out;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  out_valid;

  modport master (
    output en, data_in, state_in,
    input  state_out, data_out, out_valid
  );

  modport slave (
    input  en, data_in, state_in,
    output state_out, data_out, out_valid
  );
endinterface

// File: rtl/lfsr_step.sv
// Purpose: advance a caller-supplied LFSR state by DATA_WIDTH bit-steps (CRC / PRBS / scrambler).
// Latency: 1 cycle from an enabled edge to registered state_out/data_out with a one-cycle out_valid.
// Backpressure: none; every enabled edge is accepted and outputs hold while en is low.
// Ports: clk, rst_n (async active-low); bus (slave): en, data_in, state_in -> state_out, data_out, out_valid.
module lfsr_step #(
  parameter int                    LFSR_WIDTH        = 31,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY         = 31'h10000001,
  parameter string                 LFSR_CONFIG       = "FIBONACCI",
  parameter bit                    LFSR_FEED_FORWARD = 1'b0,
  parameter bit                    REVERSE           = 1'b0,
  parameter int                    DATA_WIDTH        = 8,
  parameter string                 STYLE             = "AUTO"
) (
  input  logic        clk,
  input  logic        rst_n,
  lfsr_step_if.slave  bus
);

  localparam bit IS_GALOIS = (LFSR_CONFIG == "GALOIS");

  // Galois taps: the x^0 term is the fed-back bit itself, so only bits 1..W-1 XOR in.
  localparam logic [LFSR_WIDTH-1:0] G_TAPS = {LFSR_POLY[LFSR_WIDTH-1:1], 1'b0};
  // Fibonacci taps: POLY[j] selects s[j-1], so POLY[W-1:1] lines up with s[W-2:0].
  localparam logic [LFSR_WIDTH-2:0] F_TAPS = LFSR_POLY[LFSR_WIDTH-1:1];

  generate
    if (LFSR_WIDTH < 2) begin : g_bad_width
      $error("lfsr_step: LFSR_WIDTH must be at least 2");
    end
    if (DATA_WIDTH < 1) begin : g_bad_dwidth
      $error("lfsr_step: DATA_WIDTH must be at least 1");
    end
    if (LFSR_CONFIG != "FIBONACCI" && LFSR_CONFIG != "GALOIS") begin : g_bad_cfg
      $error("lfsr_step: LFSR_CONFIG must be FIBONACCI or GALOIS");
    end
    if (LFSR_FEED_FORWARD && IS_GALOIS) begin : g_bad_ff
      $error("lfsr_step: feed-forward form exists only for FIBONACCI");
    end
    if (STYLE != "AUTO" && STYLE != "LOOP" && STYLE != "REDUCTION") begin : g_bad_style
      $error("lfsr_step: STYLE must be AUTO, LOOP or REDUCTION");
    end
  endgenerate

  function automatic logic [LFSR_WIDTH-1:0] rev_state(input logic [LFSR_WIDTH-1:0] v);
    logic [LFSR_WIDTH-1:0] r;
    for (int i = 0; i < LFSR_WIDTH; i++) r[i] = v[LFSR_WIDTH-1-i];
    return r;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] rev_data(input logic [DATA_WIDTH-1:0] v);
    logic [DATA_WIDTH-1:0] r;
    for (int i = 0; i < DATA_WIDTH; i++) r[i] = v[DATA_WIDTH-1-i];
    return r;
  endfunction

  logic [LFSR_WIDTH-1:0] w_s;
  logic [DATA_WIDTH-1:0] w_d;
  logic [DATA_WIDTH-1:0] w_o;
  logic                  w_fb;
  logic [LFSR_WIDTH-1:0] w_next_state;
  logic [DATA_WIDTH-1:0] w_next_data;

  logic [LFSR_WIDTH-1:0] r_state_out;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_out_valid;

  // Unrolled bit-serial step; the loop collapses into an XOR network per output bit.
  always_comb begin
    w_s  = REVERSE ? rev_state(bus.state_in) : bus.state_in;
    w_d  = REVERSE ? rev_data(bus.data_in) : bus.data_in;
    w_o  = '0;
    w_fb = 1'b0;
    for (int k = 0; k < DATA_WIDTH; k++) begin
      if (IS_GALOIS) begin
        w_fb = w_s[LFSR_WIDTH-1] ^ w_d[DATA_WIDTH-1-k];
        w_s  = {w_s[LFSR_WIDTH-2:0], w_fb} ^ ({LFSR_WIDTH{w_fb}} & G_TAPS);
      end else begin
        w_fb = w_s[LFSR_WIDTH-1] ^ w_d[DATA_WIDTH-1-k] ^ (^(w_s[LFSR_WIDTH-2:0] & F_TAPS));
        // Feed-forward shifts in the received bit, making it the exact inverse of the scrambler.
        w_s  = {w_s[LFSR_WIDTH-2:0], (LFSR_FEED_FORWARD ? w_d[DATA_WIDTH-1-k] : w_fb)};
      end
      w_o[DATA_WIDTH-1-k] = w_fb;
    end
    w_next_state = REVERSE ? rev_state(w_s) : w_s;
    w_next_data  = REVERSE ? rev_data(w_o) : w_o;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_out <= '0;
      r_data_out  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= bus.en;
      if (bus.en) begin
        r_state_out <= w_next_state;
        r_data_out  <= w_next_data;
      end
    end
  end

  assign bus.state_out = r_state_out;
  assign bus.data_out  = r_data_out;
  assign bus.out_valid = r_out_valid;

endmodule

// File: tb/tb_lfsr_step.sv
// Bench for lfsr_step: CRC-32, PRBS31, scrambler/descrambler, hold/enable, async reset, REVERSE mirror.
// Stimulus pushes expected results into per-instance queues; negedge monitors pop and compare.
// Ends with a single summary line.
module tb_lfsr_step;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        chk_s;
    logic        chk_d;
    logic [63:0] s;
    logic [63:0] d;
  } exp_t;

  exp_t q_prbs[$];
  exp_t q_crc[$];
  exp_t q_dscr[$];
  exp_t q_rev[$];
  exp_t e_prbs, e_crc, e_dscr, e_rev;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [57:0] SCR_SEED = 58'h123456789ABCDEF;

  lfsr_step_if #(.LFSR_WIDTH(31), .DATA_WIDTH(8))  if_prbs ();
  lfsr_step_if #(.LFSR_WIDTH(32), .DATA_WIDTH(8))  if_crc ();
  lfsr_step_if #(.LFSR_WIDTH(58), .DATA_WIDTH(64)) if_scr ();
  lfsr_step_if #(.LFSR_WIDTH(58), .DATA_WIDTH(64)) if_dscr ();
  lfsr_step_if #(.LFSR_WIDTH(31), .DATA_WIDTH(8))  if_r0 ();
  lfsr_step_if #(.LFSR_WIDTH(31), .DATA_WIDTH(8))  if_r1 ();

  lfsr_step u_prbs (.clk(clk), .rst_n(rst_n), .bus(if_prbs));

  lfsr_step #(
    .LFSR_WIDTH(32), .LFSR_POLY(32'h04C11DB7), .LFSR_CONFIG("GALOIS"),
    .LFSR_FEED_FORWARD(1'b0), .REVERSE(1'b1), .DATA_WIDTH(8), .STYLE("AUTO")
  ) u_crc (.clk(clk), .rst_n(rst_n), .bus(if_crc));

  lfsr_step #(
    .LFSR_WIDTH(58), .LFSR_POLY(58'h8000000001), .LFSR_CONFIG("FIBONACCI"),
    .LFSR_FEED_FORWARD(1'b0), .REVERSE(1'b0), .DATA_WIDTH(64), .STYLE("AUTO")
  ) u_scr (.clk(clk), .rst_n(rst_n), .bus(if_scr));

  lfsr_step #(
    .LFSR_WIDTH(58), .LFSR_POLY(58'h8000000001), .LFSR_CONFIG("FIBONACCI"),
    .LFSR_FEED_FORWARD(1'b1), .REVERSE(1'b0), .DATA_WIDTH(64), .STYLE("AUTO")
  ) u_dscr (.clk(clk), .rst_n(rst_n), .bus(if_dscr));

  lfsr_step #(.REVERSE(1'b0)) u_r0 (.clk(clk), .rst_n(rst_n), .bus(if_r0));
  lfsr_step #(.REVERSE(1'b1)) u_r1 (.clk(clk), .rst_n(rst_n), .bus(if_r1));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // PRBS31 reference: x^31 + x^28 + 1, Fibonacci, MSB of data first.
  function automatic logic [38:0] prbs_ref(input logic [30:0] s, input logic [7:0] d);
    logic [30:0] st;
    logic [7:0]  o;
    logic        fb;
    st = s;
    o  = '0;
    for (int k = 0; k < 8; k++) begin
      fb = st[30] ^ st[27] ^ d[7-k];
      st = {st[29:0], fb};
      o[7-k] = fb;
    end
    return {st, o};
  endfunction

  function automatic logic [30:0] rev31(input logic [30:0] v);
    logic [30:0] r;
    for (int i = 0; i < 31; i++) r[i] = v[30-i];
    return r;
  endfunction

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  // Bench-side record of en as seen at each edge, for the out_valid check.
  logic en_q;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) en_q <= 1'b0;
    else        en_q <= if_prbs.en;
  end

  // PRBS monitor: scoreboard pop on valid, hold check otherwise, out_valid vs delayed en.
  logic [63:0] last_s, last_d;
  always @(negedge clk) begin
    if (!rst_n) begin
      last_s = '0;
      last_d = '0;
    end else begin
      check("prbs_out_valid", 64'(if_prbs.out_valid), 64'(en_q));
      if (if_prbs.out_valid) begin
        if (q_prbs.size() == 0) begin
          check("prbs_unexpected_valid", 64'(1), 64'(0));
        end else begin
          e_prbs = q_prbs.pop_front();
          check("prbs_state", 64'(if_prbs.state_out), e_prbs.s);
          check("prbs_data", 64'(if_prbs.data_out), e_prbs.d);
          last_s = e_prbs.s;
          last_d = e_prbs.d;
        end
      end else begin
        check("prbs_hold_state", 64'(if_prbs.state_out), last_s);
        check("prbs_hold_data", 64'(if_prbs.data_out), last_d);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && if_crc.out_valid) begin
      if (q_crc.size() == 0) begin
        check("crc_unexpected_valid", 64'(1), 64'(0));
      end else begin
        e_crc = q_crc.pop_front();
        if (e_crc.chk_s) check("crc32_state", 64'(if_crc.state_out), e_crc.s);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && if_dscr.out_valid) begin
      if (q_dscr.size() == 0) begin
        check("dscr_unexpected_valid", 64'(1), 64'(0));
      end else begin
        e_dscr = q_dscr.pop_front();
        if (e_dscr.chk_d) check("descrambled_data", if_dscr.data_out, e_dscr.d);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && if_r0.out_valid) begin
      if (q_rev.size() == 0) begin
        check("rev_unexpected_valid", 64'(1), 64'(0));
      end else begin
        e_rev = q_rev.pop_front();
        check("rev0_state", 64'(if_r0.state_out), e_rev.s);
        check("rev0_data", 64'(if_r0.data_out), e_rev.d);
        check("rev1_valid", 64'(if_r1.out_valid), 64'(1));
        check("rev1_state", 64'(if_r1.state_out), 64'(rev31(e_rev.s[30:0])));
        check("rev1_data", 64'(if_r1.data_out), 64'(rev8(e_rev.d[7:0])));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  logic [30:0] cur, s_r;
  logic [7:0]  d_r;
  logic [38:0] res;
  logic [15:0] en_pat;
  logic [63:0] xv [8];

  initial begin
    if_prbs.en = 0; if_prbs.data_in = '0; if_prbs.state_in = '0;
    if_crc.en  = 0; if_crc.data_in  = '0; if_crc.state_in  = '0;
    if_scr.en  = 0; if_scr.data_in  = '0; if_scr.state_in  = '0;
    if_dscr.en = 0; if_dscr.data_in = '0; if_dscr.state_in = '0;
    if_r0.en   = 0; if_r0.data_in   = '0; if_r0.state_in   = '0;
    if_r1.en   = 0; if_r1.data_in   = '0; if_r1.state_in   = '0;
    xv[0] = 64'h0000000000000000; xv[1] = 64'hFFFFFFFFFFFFFFFF;
    xv[2] = 64'hDEADBEEFCAFEF00D; xv[3] = 64'h0123456789ABCDEF;
    xv[4] = 64'h8000000000000001; xv[5] = 64'h5555AAAA3333CCCC;
    xv[6] = {$urandom, $urandom};  xv[7] = {$urandom, $urandom};

    repeat (3) @(negedge clk);
    check("rst_prbs_state", 64'(if_prbs.state_out), 64'(0));
    check("rst_prbs_data", 64'(if_prbs.data_out), 64'(0));
    check("rst_prbs_valid", 64'(if_prbs.out_valid), 64'(0));
    check("rst_crc_state", 64'(if_crc.state_out), 64'(0));
    check("rst_dscr_data", if_dscr.data_out, 64'(0));
    #2 rst_n = 1'b1;
    @(negedge clk);

    // PRBS31 from all-ones with zero data.
    if_prbs.en = 1; if_prbs.state_in = 31'h7FFFFFFF; if_prbs.data_in = 8'h00;
    q_prbs.push_back('{1'b1, 1'b1, 64'h7FFFFF00, 64'h00});
    @(negedge clk);

    // Hold/enable: junk inputs while en is low must be ignored.
    en_pat = 16'b1011_0011_1000_1101;
    cur = 31'h1234567;
    for (int i = 0; i < 16; i++) begin
      if_prbs.en = en_pat[i];
      if (en_pat[i]) begin
        d_r = 8'($urandom);
        if_prbs.state_in = cur;
        if_prbs.data_in  = d_r;
        res = prbs_ref(cur, d_r);
        q_prbs.push_back('{1'b1, 1'b1, 64'(res[38:8]), 64'(res[7:0])});
        cur = res[38:8];
      end else begin
        if_prbs.state_in = 31'($urandom);
        if_prbs.data_in  = 8'($urandom);
      end
      @(negedge clk);
    end

    // Async reset landing while a fresh result is valid.
    if_prbs.en = 1; if_prbs.state_in = cur; if_prbs.data_in = 8'hA5;
    @(posedge clk); #2;
    check("prbs_valid_before_rst", 64'(if_prbs.out_valid), 64'(1));
    rst_n = 1'b0;
    if_prbs.en = 0;
    #1;
    check("async_rst_state", 64'(if_prbs.state_out), 64'(0));
    check("async_rst_data", 64'(if_prbs.data_out), 64'(0));
    check("async_rst_valid", 64'(if_prbs.out_valid), 64'(0));
    @(negedge clk); @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    res = prbs_ref(cur, 8'h3C);
    if_prbs.en = 1; if_prbs.state_in = cur; if_prbs.data_in = 8'h3C;
    q_prbs.push_back('{1'b1, 1'b1, 64'(res[38:8]), 64'(res[7:0])});
    @(negedge clk);
    if_prbs.en = 0;

    // CRC-32 of "123456789", state chained every cycle.
    for (int i = 0; i < 9; i++) begin
      if_crc.en = 1;
      if_crc.data_in  = 8'h31 + 8'(i);
      if_crc.state_in = (i == 0) ? 32'hFFFFFFFF : if_crc.state_out;
      if (i == 8) q_crc.push_back('{1'b1, 1'b0, 64'h340BC6D9, 64'h0});
      else        q_crc.push_back('{1'b0, 1'b0, 64'h0, 64'h0});
      @(negedge clk);
    end
    if_crc.en = 0;

    // Scrambler feeds descrambler one cycle later; both start from the same seed.
    for (int c = 0; c <= 8; c++) begin
      if (c < 8) begin
        if_scr.en = 1;
        if_scr.data_in  = xv[c];
        if_scr.state_in = (c == 0) ? SCR_SEED : if_scr.state_out;
      end else begin
        if_scr.en = 0;
      end
      if (c >= 1) begin
        if_dscr.en = 1;
        if_dscr.data_in  = if_scr.data_out;
        if_dscr.state_in = (c == 1) ? SCR_SEED : if_dscr.state_out;
        q_dscr.push_back('{1'b0, 1'b1, 64'h0, xv[c-1]});
      end
      @(negedge clk);
    end
    if_dscr.en = 0;

    // REVERSE=1 fed (s,d) must mirror REVERSE=0 fed reversed (s,d).
    for (int i = 0; i < 6; i++) begin
      s_r = 31'($urandom);
      d_r = 8'($urandom);
      if_r0.en = 1; if_r0.state_in = rev31(s_r); if_r0.data_in = rev8(d_r);
      if_r1.en = 1; if_r1.state_in = s_r;        if_r1.data_in = d_r;
      res = prbs_ref(rev31(s_r), rev8(d_r));
      q_rev.push_back('{1'b1, 1'b1, 64'(res[38:8]), 64'(res[7:0])});
      @(negedge clk);
    end
    if_r0.en = 0; if_r1.en = 0;

    repeat (3) @(negedge clk);
    check("prbs_pending", 64'(q_prbs.size()), 64'(0));
    check("crc_pending", 64'(q_crc.size()), 64'(0));
    check("dscr_pending", 64'(q_dscr.size()), 64'(0));
    check("rev_pending", 64'(q_rev.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
